// File: rtl/pragmatic_mult.sv
// Essential-bit serial multiplier: one RUN cycle per set bit of the multiplier,
// with runtime 4/8/16/32-bit precision and build-time signedness.
module pragmatic_mult #(
    parameter int unsigned MAX_WIDTH = 16,
    parameter bit          SIGNED    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             precision,
    input  logic [MAX_WIDTH-1:0]   jia,
    input  logic [MAX_WIDTH-1:0]   yi,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [2*MAX_WIDTH-1:0] zi,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5:0]             cycles
);

    localparam int unsigned AW = 2 * MAX_WIDTH;
    localparam int unsigned KW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          a_q, a_d;
    logic [MAX_WIDTH-1:0]   m_q, m_d;
    logic [6:0]             p_q, p_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [AW-1:0]          zi_q, zi_d;
    logic [5:0]             cycles_q, cycles_d;

    logic [6:0]             p_eff;
    logic [AW-1:0]          low_mask;
    logic                   jia_sign;
    logic [AW-1:0]          jia_ext;
    logic [MAX_WIDTH-1:0]   yi_masked;

    logic [KW-1:0]          k;
    logic [AW-1:0]          shifted;
    logic                   is_msb;
    logic [AW-1:0]          acc_next;
    logic [MAX_WIDTH-1:0]   m_next;

    // Effective width, low-P mask and operand extension for the accept path
    always_comb begin
        p_eff = 7'(32'd4 << precision);
        if (p_eff > 7'(MAX_WIDTH)) begin
            p_eff = 7'(MAX_WIDTH);
        end
        for (int i = 0; i < int'(AW); i++) begin
            low_mask[i] = (i < int'(p_eff));
        end
        jia_sign = 1'b0;
        for (int i = 0; i < int'(MAX_WIDTH); i++) begin
            if (i == int'(p_eff) - 1) begin
                jia_sign = jia[i];
            end
        end
        if (!SIGNED) begin
            jia_sign = 1'b0;
        end
        jia_ext   = ({{MAX_WIDTH{1'b0}}, jia} & low_mask) | ({AW{jia_sign}} & ~low_mask);
        yi_masked = yi & low_mask[MAX_WIDTH-1:0];
    end

    // Lowest-set-bit priority encoder and the per-cycle accumulate step
    always_comb begin
        k = '0;
        for (int i = int'(MAX_WIDTH) - 1; i >= 0; i--) begin
            if (m_q[i]) begin
                k = KW'(i);
            end
        end
        shifted = a_q << k;
        // Top bit of a two's-complement multiplier carries negative weight
        is_msb  = SIGNED && (int'(k) == int'(p_q) - 1);
        if (m_q == '0) begin
            acc_next = acc_q;
        end else if (is_msb) begin
            acc_next = acc_q - shifted;
        end else begin
            acc_next = acc_q + shifted;
        end
        m_next = m_q & (m_q - MAX_WIDTH'(1));
    end

    // Next-state logic; en=0 leaves every register at its current value
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        m_d      = m_q;
        p_d      = p_q;
        acc_d    = acc_q;
        zi_d     = zi_q;
        cycles_d = cycles_q;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_d      = jia_ext;
                        m_d      = yi_masked;
                        p_d      = p_eff;
                        acc_d    = '0;
                        cycles_d = '0;
                        // An empty mask still spends one RUN cycle (adding nothing),
                        // so out_valid is never earlier than one cycle after accept.
                        state_d  = StRun;
                    end
                end
                StRun: begin
                    acc_d = acc_next;
                    m_d   = m_next;
                    if (m_q != '0) begin
                        cycles_d = cycles_q + 6'd1;
                    end
                    if (m_next == '0) begin
                        zi_d    = acc_next;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            m_q      <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            zi_q     <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            m_q      <= m_d;
            p_q      <= p_d;
            acc_q    <= acc_d;
            zi_q     <= zi_d;
            cycles_q <= cycles_d;
        end
    end

    assign in_ready  = en && !rst && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign zi        = zi_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_pragmatic_mult.sv
// Self-checking bench for pragmatic_mult (SIGNED=1, MAX_WIDTH=16).
module tb_pragmatic_mult;

    localparam int W  = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    precision;
    logic [W-1:0]  jia;
    logic [W-1:0]  yi;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] zi;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    cycles;

    pragmatic_mult #(
        .MAX_WIDTH(W),
        .SIGNED   (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .precision(precision),
        .jia      (jia),
        .yi       (yi),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .zi       (zi),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]    prec;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] zi;
        logic [5:0]    cyc;
    } vec_t;

    typedef struct {
        logic [AW-1:0] zi;
        logic [5:0]    cyc;
        int            lat;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact signed product of the P-bit operands
    function automatic logic [AW-1:0] model_prod(input logic [1:0] prec, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        int p;
        longint sa, sbv;
        p = 4 << prec;
        if (p > W) p = W;
        sa  = a[p-1] ? -64'sd1 : 64'sd0;
        sbv = b[p-1] ? -64'sd1 : 64'sd0;
        for (int i = 0; i < p; i++) begin
            sa[i]  = a[i];
            sbv[i] = b[i];
        end
        return AW'(sa * sbv);
    endfunction

    function automatic logic [5:0] model_pop(input logic [1:0] prec, input logic [W-1:0] b);
        int p;
        int n;
        p = 4 << prec;
        if (p > W) p = W;
        n = 0;
        for (int i = 0; i < p; i++) n += int'(b[i]);
        return 6'(n);
    endfunction

    // Wait for in_ready, present one operand pair, push the expectation
    task automatic issue(input logic [1:0] prec, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] ezi, input logic [5:0] ecyc, input int elat);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 within 40 cycles");
        end
        precision = prec;
        jia       = a;
        yi        = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        jia       = 16'hDEAD;
        yi        = 16'hBEEF;
        sb.push_back('{zi: ezi, cyc: ecyc, lat: elat});
    endtask

    // Count cycles to out_valid, compare against the scoreboard, optionally
    // stall the handoff for 'hold' cycles, then hand off
    task automatic collect(input string tag, input int hold);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: got empty scoreboard expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_zi"}, 64'(zi), 64'(e.zi));
        check({tag, "_cycles"}, 64'(cycles), 64'(e.cyc));
        for (int h = 0; h < hold; h++) begin
            precision = 2'd1;
            jia       = 16'h0011;
            yi        = 16'h0011;
            in_valid  = 1'b1;
            @(posedge clk);
            #1;
            check({tag, "_hold_zi"}, 64'(zi), 64'(e.zi));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{prec: 2'd1, a: 16'h0005, b: 16'h000B, zi: 32'd55,        cyc: 6'd3};
        vecs[1] = '{prec: 2'd1, a: 16'h0007, b: 16'h00FF, zi: 32'hFFFFFFF9,  cyc: 6'd8};
        vecs[2] = '{prec: 2'd1, a: 16'h1234, b: 16'h0000, zi: 32'd0,         cyc: 6'd0};
        vecs[3] = '{prec: 2'd0, a: 16'hFFF3, b: 16'h0FF2, zi: 32'd6,         cyc: 6'd1};
        vecs[4] = '{prec: 2'd2, a: 16'hFFFE, b: 16'h0003, zi: 32'hFFFFFFFA,  cyc: 6'd2};
        vecs[5] = '{prec: 2'd3, a: 16'h8000, b: 16'h8000, zi: 32'h40000000,  cyc: 6'd1};
        vecs[6] = '{prec: 2'd0, a: 16'h000F, b: 16'h0008, zi: 32'd8,         cyc: 6'd1};
        vecs[7] = '{prec: 2'd1, a: 16'h0080, b: 16'h0080, zi: 32'h00004000,  cyc: 6'd1};
        vecs[8] = '{prec: 2'd2, a: 16'h0003, b: 16'h00F0, zi: 32'd720,       cyc: 6'd4};
        vecs[9] = '{prec: 2'd2, a: 16'h00FF, b: 16'h0101, zi: 32'h0000FFFF,  cyc: 6'd2};

        rst       = 1'b0;
        en        = 1'b1;
        precision = 2'd0;
        jia       = '0;
        yi        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_zi", 64'(zi), 64'd0);
        check("reset_cycles", 64'(cycles), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_reset_ready", 64'(in_ready), 64'd1);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].prec, vecs[i].a, vecs[i].b, vecs[i].zi, vecs[i].cyc,
                  (vecs[i].cyc == 0) ? 1 : int'(vecs[i].cyc));
            collect($sformatf("vec%0d", i), 0);
        end

        // Random vectors against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            logic [1:0]   p;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [5:0]   c;
            p = 2'($urandom_range(0, 3));
            a = W'($urandom);
            b = W'($urandom & $urandom);
            c = model_pop(p, b);
            issue(p, a, b, model_prod(p, a, b), c, (c == 0) ? 1 : int'(c));
            collect($sformatf("rnd%0d", i), 0);
        end

        // DONE held with out_ready low while new operands are offered
        issue(2'd1, 16'h0005, 16'h000B, 32'd55, 6'd3, 3);
        collect("hold", 5);

        // en low in IDLE forces in_ready low
        en = 1'b0;
        #1;
        check("en_idle_ready", 64'(in_ready), 64'd0);
        en = 1'b1;
        #1;

        // en pulsed low for 3 cycles mid-RUN stretches latency by 3
        issue(2'd2, 16'h0003, 16'h00F0, 32'd720, 6'd4, 7);
        fork
            begin
                repeat (2) @(posedge clk);
                #1 en = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("en_freeze_cycles", 64'(cycles), 64'd2);
                en = 1'b1;
            end
        join_none
        collect("en_pause", 0);

        // Asynchronous reset mid-RUN aborts the product
        issue(2'd1, 16'h0007, 16'h00FF, 32'hFFFFFFF9, 6'd8, 8);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrun_rst_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_zi", 64'(zi), 64'd0);
        check("midrun_rst_cycles", 64'(cycles), 64'd0);
        check("midrun_rst_ready", 64'(in_ready), 64'd0);
        void'(sb.pop_front());
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        issue(2'd1, 16'h0005, 16'h000B, 32'd55, 6'd3, 3);
        collect("after_rst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
